// File: rtl/data_ram_pkg.sv
// data_ram_pkg: shared FSM/owner encodings and default RAM size for the data RAM arbiter.
package data_ram_pkg;
    typedef enum logic [1:0] {IDLE, CPU_ACCESS, IO_ACCESS} stateType;
    typedef enum logic {OWNER_CPU = 1'b0, OWNER_IO = 1'b1} ownerType;
    localparam int DEFAULT_RAM_DEPTH = 21;
endpackage

// File: rtl/rr_owner_select.sv
// rr_owner_select: combinational next-state choice with round-robin ties and bounded lock bursts.
module rr_owner_select
    import data_ram_pkg::*;
#(
    parameter int MAX_BURST   = 4,
    parameter int COUNT_WIDTH = 2
) (
    input  stateType               state,
    input  ownerType               lastOwner,
    input  logic [COUNT_WIDTH-1:0] burstCount,
    input  logic                   cpuRequest,
    input  logic                   ioRequest,
    input  logic                   cpuLock,
    input  logic                   ioLock,
    output stateType               nextState
);
    logic isCpu, ownerLock, otherRequest, stay;
    stateType otherState, idleChoice;
    assign isCpu        = state == CPU_ACCESS;
    assign ownerLock    = isCpu ? cpuLock : ioLock;
    assign otherRequest = isCpu ? ioRequest : cpuRequest;
    assign otherState   = isCpu ? IO_ACCESS : CPU_ACCESS;
    // A lock only yields to a waiting requester once the burst limit is reached.
    assign stay = ownerLock && (int'(burstCount) < MAX_BURST - 1 || !otherRequest);
    assign idleChoice = (cpuRequest && ioRequest) ? (lastOwner == OWNER_IO ? CPU_ACCESS : IO_ACCESS)
                      : cpuRequest ? CPU_ACCESS : ioRequest ? IO_ACCESS : IDLE;
    assign nextState = (state == IDLE) ? idleChoice : stay ? state : otherRequest ? otherState : IDLE;
endmodule

// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter: two-requester (CPU/IO) arbiter for a single-port data RAM
// with lockable bursts, range checking and registered shared read data.
module data_ram_arbiter
    import data_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int RAM_DEPTH  = DEFAULT_RAM_DEPTH,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cpuRequest,
    input  logic                  ioRequest,
    input  logic                  cpuWriteEnable,
    input  logic                  ioWriteEnable,
    input  logic [ADDR_WIDTH-1:0] cpuAddress,
    input  logic [ADDR_WIDTH-1:0] ioAddress,
    input  logic [DATA_WIDTH-1:0] cpuData,
    input  logic [DATA_WIDTH-1:0] ioData,
    input  logic                  cpuLock,
    input  logic                  ioLock,
    output logic                  cpuGrant,
    output logic                  ioGrant,
    output logic                  cpuReadValid,
    output logic                  ioReadValid,
    output logic [DATA_WIDTH-1:0] readData,
    output logic                  addressError,
    output logic [ADDR_WIDTH-1:0] ramAddress,
    output logic [DATA_WIDTH-1:0] ramData,
    output logic                  ramWriteEnable,
    input  logic [DATA_WIDTH-1:0] ramReadData
);
    localparam int COUNT_WIDTH = MAX_BURST > 2 ? $clog2(MAX_BURST) : 1;

    stateType state, nextState;
    ownerType lastOwner;
    logic [COUNT_WIDTH-1:0] burstCount;
    logic ownerRequest, ownerWriteEnable, inRange, readStrobe;

    rr_owner_select #(.MAX_BURST(MAX_BURST), .COUNT_WIDTH(COUNT_WIDTH)) ownerSelect (
        .state(state), .lastOwner(lastOwner), .burstCount(burstCount),
        .cpuRequest(cpuRequest), .ioRequest(ioRequest),
        .cpuLock(cpuLock), .ioLock(ioLock), .nextState(nextState)
    );

    assign cpuGrant         = state == CPU_ACCESS;
    assign ioGrant          = state == IO_ACCESS;
    assign ownerRequest     = cpuGrant ? cpuRequest : ioGrant ? ioRequest : 1'b0;
    assign ownerWriteEnable = cpuGrant ? cpuWriteEnable : ioGrant ? ioWriteEnable : 1'b0;
    assign ramAddress       = cpuGrant ? cpuAddress : ioGrant ? ioAddress : '0;
    assign ramData          = cpuGrant ? cpuData : ioGrant ? ioData : '0;
    assign inRange          = int'(ramAddress) < RAM_DEPTH;
    assign ramWriteEnable   = ownerRequest && ownerWriteEnable && inRange;
    assign readStrobe       = ownerRequest && !ownerWriteEnable;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            lastOwner    <= OWNER_IO;
            burstCount   <= '0;
            readData     <= '0;
            cpuReadValid <= 1'b0;
            ioReadValid  <= 1'b0;
            addressError <= 1'b0;
        end else begin
            state <= nextState;
            if (cpuGrant || ioGrant)
                lastOwner <= cpuGrant ? OWNER_CPU : OWNER_IO;
            // Saturate so a long uncontested lock cannot wrap and overstay later.
            burstCount <= ((cpuGrant || ioGrant) && nextState == state)
                        ? ((int'(burstCount) < MAX_BURST - 1) ? burstCount + 1'b1 : burstCount)
                        : '0;
            cpuReadValid <= cpuGrant && readStrobe;
            ioReadValid  <= ioGrant && readStrobe;
            if (readStrobe)
                readData <= inRange ? ramReadData : '0;
            addressError <= ownerRequest && !inRange;
        end
    end
endmodule

// File: tb/tb_data_ram_arbiter.sv
// tb_data_ram_arbiter: directed checks of grant order, bursts, latency, range errors and reset abort.
module tb_data_ram_arbiter;
    logic        clock, reset;
    logic        cpuRequest, ioRequest, cpuWriteEnable, ioWriteEnable, cpuLock, ioLock;
    logic [9:0]  cpuAddress, ioAddress, ramAddress;
    logic [31:0] cpuData, ioData, readData, ramData, ramReadData;
    logic        cpuGrant, ioGrant, cpuReadValid, ioReadValid, addressError, ramWriteEnable;
    logic [31:0] mem [0:1023];
    int passed = 0;
    int total  = 0;

    data_ram_arbiter dut (
        .clock(clock), .reset(reset),
        .cpuRequest(cpuRequest), .ioRequest(ioRequest),
        .cpuWriteEnable(cpuWriteEnable), .ioWriteEnable(ioWriteEnable),
        .cpuAddress(cpuAddress), .ioAddress(ioAddress),
        .cpuData(cpuData), .ioData(ioData),
        .cpuLock(cpuLock), .ioLock(ioLock),
        .cpuGrant(cpuGrant), .ioGrant(ioGrant),
        .cpuReadValid(cpuReadValid), .ioReadValid(ioReadValid),
        .readData(readData), .addressError(addressError),
        .ramAddress(ramAddress), .ramData(ramData),
        .ramWriteEnable(ramWriteEnable), .ramReadData(ramReadData)
    );

    initial clock = 0;
    always #5 clock = ~clock;

    assign ramReadData = mem[ramAddress];
    always @(posedge clock) if (ramWriteEnable) mem[ramAddress] <= ramData;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA0 + i;
        reset = 1;
        {cpuRequest, ioRequest, cpuWriteEnable, ioWriteEnable, cpuLock, ioLock} = '0;
        cpuAddress = '0; ioAddress = '0; cpuData = '0; ioData = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_cpuGrant", cpuGrant, 0);
        check("rst_ioGrant", ioGrant, 0);
        check("rst_readData", readData, 0);
        check("rst_cpuReadValid", cpuReadValid, 0);
        check("rst_ioReadValid", ioReadValid, 0);
        check("rst_addressError", addressError, 0);
        check("rst_ramWriteEnable", ramWriteEnable, 0);
        check("rst_ramAddress", ramAddress, 0);
        reset = 0;

        // Tie after reset: CPU first, IO next, then IDLE
        cpuRequest = 1; ioRequest = 1; cpuAddress = 1; ioAddress = 2;
        tick;
        check("tie_cpuGrant", cpuGrant, 1);
        check("tie_ioGrant0", ioGrant, 0);
        tick;
        check("tie_ioGrant", ioGrant, 1);
        check("tie_cpuGrant0", cpuGrant, 0);
        check("tie_cpuReadValid", cpuReadValid, 1);
        check("tie_readData_cpu", readData, 32'hA1);
        cpuRequest = 0;
        tick;
        check("tie_idle_cpu", cpuGrant, 0);
        check("tie_idle_io", ioGrant, 0);
        check("tie_ioReadValid", ioReadValid, 1);
        check("tie_readData_io", readData, 32'hA2);
        ioRequest = 0;

        // CPU write then read of address 5
        cpuRequest = 1; cpuWriteEnable = 1; cpuAddress = 5; cpuData = 32'hDEADBEEF;
        tick;
        check("wr_cpuGrant", cpuGrant, 1);
        check("wr_ramWriteEnable", ramWriteEnable, 1);
        check("wr_ramAddress", ramAddress, 5);
        check("wr_ramData", ramData, 32'hDEADBEEF);
        tick;
        check("wr_mem5", mem[5], 32'hDEADBEEF);
        check("wr_idle", cpuGrant, 0);
        cpuWriteEnable = 0;
        tick;
        check("rd_cpuGrant", cpuGrant, 1);
        check("rd_ramWriteEnable", ramWriteEnable, 0);
        check("rd_readValid_early", cpuReadValid, 0);
        tick;
        check("rd_readData", readData, 32'hDEADBEEF);
        check("rd_cpuReadValid", cpuReadValid, 1);
        cpuRequest = 0;
        tick;
        check("rd_valid_pulse", cpuReadValid, 0);
        check("rd_hold", readData, 32'hDEADBEEF);

        // Locked CPU burst against a waiting IO requester
        cpuRequest = 1; cpuLock = 1; cpuAddress = 7;
        tick;
        check("burst_g1", cpuGrant, 1);
        ioRequest = 1; ioAddress = 8;
        tick;
        check("burst_g2", cpuGrant, 1);
        check("burst_valid2", cpuReadValid, 1);
        tick;
        check("burst_g3", cpuGrant, 1);
        tick;
        check("burst_g4", cpuGrant, 1);
        tick;
        check("burst_io", ioGrant, 1);
        check("burst_io_cpu0", cpuGrant, 0);
        tick;
        check("burst_resume", cpuGrant, 1);
        check("burst_ioReadValid", ioReadValid, 1);
        check("burst_readData_io", readData, 32'hA8);
        ioRequest = 0;
        tick;
        check("burst_g6", cpuGrant, 1);
        cpuLock = 0;
        tick;
        check("burst_end_cpu", cpuGrant, 0);
        check("burst_end_io", ioGrant, 0);
        cpuRequest = 0;

        // IO out-of-range write then read at address 21
        ioRequest = 1; ioWriteEnable = 1; ioAddress = 21; ioData = 32'h12345678;
        tick;
        check("oor_wr_ioGrant", ioGrant, 1);
        check("oor_wr_ramWriteEnable", ramWriteEnable, 0);
        check("oor_wr_err_early", addressError, 0);
        tick;
        check("oor_wr_addressError", addressError, 1);
        check("oor_wr_mem21", mem[21], 32'hB5);
        ioWriteEnable = 0;
        tick;
        check("oor_rd_ioGrant", ioGrant, 1);
        check("oor_rd_err_clear", addressError, 0);
        tick;
        check("oor_rd_readData", readData, 0);
        check("oor_rd_ioReadValid", ioReadValid, 1);
        check("oor_rd_addressError", addressError, 1);
        ioRequest = 0;
        tick;
        check("oor_err_pulse", addressError, 0);

        // Reset aborting a CPU write to address 3
        cpuRequest = 1; cpuWriteEnable = 1; cpuAddress = 3; cpuData = 32'h55555555;
        tick;
        check("abort_cpuGrant", cpuGrant, 1);
        check("abort_we_before", ramWriteEnable, 1);
        reset = 1;
        #1;
        check("abort_cpuGrant0", cpuGrant, 0);
        check("abort_ramWriteEnable", ramWriteEnable, 0);
        check("abort_ramAddress", ramAddress, 0);
        tick;
        check("abort_mem3", mem[3], 32'hA3);
        check("abort_cpuReadValid", cpuReadValid, 0);
        check("abort_addressError", addressError, 0);
        cpuWriteEnable = 0; ioRequest = 1; ioWriteEnable = 0; ioAddress = 4;
        reset = 0;
        tick;
        check("post_cpuGrant", cpuGrant, 1);
        check("post_ioGrant0", ioGrant, 0);
        check("post_readValid0", cpuReadValid, 0);
        tick;
        check("post_ioGrant", ioGrant, 1);
        check("post_cpuReadValid", cpuReadValid, 1);
        check("post_readData", readData, 32'hA3);
        cpuRequest = 0;
        tick;
        ioRequest = 0;
        tick;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
